// File: rtl/seq_stream_ctrl.sv
// Word-to-bit serializer with a programmable-pattern sequence matcher, match counter and run framing.
// Optional build macro SEQ_CTRL_FIRST_IDX_EN enables capture of the bit index of the first match.
module seq_stream_ctrl #(
    parameter int WORD_W = 8,
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_we,
    input  logic [PAT_W-1:0]           cfg_pattern,
    input  logic [$clog2(PAT_W+1)-1:0] cfg_len,
    input  logic                       cfg_overlap,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [WORD_W-1:0]          s_data,
    input  logic                       s_last,
    output logic                       bit_out,
    output logic                       bit_valid,
    output logic                       det_pulse,
    output logic [CNT_W-1:0]           match_cnt,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_W-1:0]           first_idx,
    output logic                       first_vld
);

    localparam int LEN_W = $clog2(PAT_W + 1);
    localparam int BIT_W = $clog2(WORD_W);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SHIFT,
        DONE
    } state_t;

    state_t             state;
    logic [WORD_W-1:0]  shifter;
    logic               last_q;
    logic [BIT_W-1:0]   bit_cnt;
    logic [PAT_W-1:0]   pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic               overlap_q;
    logic [PAT_W-1:0]   history;
    logic [LEN_W-1:0]   fill;
    logic [CNT_W-1:0]   bit_idx;

    logic [PAT_W-1:0]   hist_next;
    logic [PAT_W-1:0]   pat_mask;
    logic [LEN_W-1:0]   fill_next;
    logic [CNT_W-1:0]   idx_next;
    logic [LEN_W-1:0]   cfg_len_eff;
    logic               hit;
    logic               take_bit;

    assign s_ready   = (state == WAIT);
    assign bit_valid = (state == SHIFT);
    assign bit_out   = bit_valid & shifter[WORD_W-1];
    assign busy      = (state != IDLE);
    assign take_bit  = (state == SHIFT) && !abort;

    // NOTE: every variable gets a value at the top of always_comb, so no path can infer a latch.
    always_comb begin
        hist_next   = (history << 1) | PAT_W'(shifter[WORD_W-1]);
        fill_next   = (fill == LEN_W'(PAT_W)) ? fill : fill + 1'b1;
        idx_next    = (&bit_idx) ? bit_idx : bit_idx + 1'b1;
        pat_mask    = ~({PAT_W{1'b1}} << len_q);
        hit         = (fill_next >= len_q) && (((hist_next ^ pattern_q) & pat_mask) == '0);
        cfg_len_eff = cfg_len;
        if (cfg_len == '0) begin
            cfg_len_eff = LEN_W'(1);
        end else if (cfg_len > LEN_W'(PAT_W)) begin
            cfg_len_eff = LEN_W'(PAT_W);
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shifter   <= '0;
            last_q    <= 1'b0;
            bit_cnt   <= '0;
            pattern_q <= '0;
            len_q     <= LEN_W'(PAT_W);
            overlap_q <= 1'b1;
            history   <= '0;
            fill      <= '0;
            bit_idx   <= '0;
            det_pulse <= 1'b0;
            match_cnt <= '0;
            done      <= 1'b0;
        end else begin
            det_pulse <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_we) begin
                        pattern_q <= cfg_pattern;
                        len_q     <= cfg_len_eff;
                        overlap_q <= cfg_overlap;
                    end
                    if (start) begin
                        history   <= '0;
                        fill      <= '0;
                        bit_idx   <= '0;
                        match_cnt <= '0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (s_valid) begin
                        shifter <= s_data;
                        last_q  <= s_last;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        shifter <= shifter << 1;
                        history <= hist_next;
                        bit_idx <= idx_next;
                        bit_cnt <= bit_cnt + 1'b1;
                        // Non-overlap mode restarts the fill so the next match needs len fresh bits.
                        if (hit) begin
                            det_pulse <= 1'b1;
                            fill      <= overlap_q ? fill_next : '0;
                            if (!(&match_cnt)) begin
                                match_cnt <= match_cnt + 1'b1;
                            end
                        end else begin
                            fill <= fill_next;
                        end
                        if (bit_cnt == BIT_W'(WORD_W - 1)) begin
                            bit_cnt <= '0;
                            if (last_q) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= WAIT;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SEQ_CTRL_FIRST_IDX_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            first_idx <= '0;
            first_vld <= 1'b0;
        end else if ((state == IDLE) && start) begin
            first_idx <= '0;
            first_vld <= 1'b0;
        end else if (take_bit && hit && !first_vld) begin
            first_idx <= idx_next;
            first_vld <= 1'b1;
        end
    end
`else
    assign first_idx = '0;
    assign first_vld = 1'b0;
`endif

endmodule

// File: doc/seq_stream_ctrl.md
Name: seq_stream_ctrl

Overview:
Controller and scheduler for the serial sequence detectors in the sequence-identifier family. It accepts parallel words over a valid/ready handshake and serializes them MSB-first, one bit per cycle, onto a detector bit stream. It runs a programmable-pattern matcher on that stream, counts detections, and frames each run with start/abort/done control. Software programs the pattern, length and overlap mode while the block is idle.

Parameters:
WORD_W, 8, input word width (bits serialized per word), >=2
PAT_W, 4, maximum pattern length in bits, >=1
CNT_W, 16, width of match counter and bit index

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
cfg_we  in  1  config write strobe, honoured only in IDLE
cfg_pattern  in  PAT_W  pattern; bit [len-1] is compared to the oldest bit, bit 0 to the newest
cfg_len  in  $clog2(PAT_W+1)  active pattern length
cfg_overlap  in  1  1 = overlapping matches allowed
start  in  1  begin run, honoured only in IDLE
abort  in  1  terminate run
s_valid  in  1  input word valid
s_ready  out  1  input word ready
s_data  in  WORD_W  input word
s_last  in  1  final word of run
bit_out  out  1  serialized bit
bit_valid  out  1  bit_out qualifier
det_pulse  out  1  one-cycle match indication
match_cnt  out  CNT_W  matches since last start, saturating
busy  out  1  state != IDLE
done  out  1  one-cycle end-of-run pulse
first_idx  out  CNT_W  bit index of first match (optional feature)
first_vld  out  1  first_idx valid (optional feature)

Behaviour:
- Reset: state IDLE; all outputs 0; pattern reg 0; len reg PAT_W; overlap reg 1; history, fill count and bit index 0.
- Config: cfg_we in IDLE latches pattern, len and overlap. cfg_we in any other state is ignored. len 0 is treated as 1; len >PAT_W is clamped to PAT_W.
- States: IDLE, WAIT, SHIFT, DONE.
- IDLE: s_ready=0. If start: clear history, fill count, bit index, match_cnt and first_vld, then go to WAIT. start outside IDLE is ignored.
- WAIT: s_ready=1 (combinational from state). On s_valid&&s_ready, latch s_data and s_last, then go to SHIFT.
- SHIFT:
  - Each cycle: bit_valid=1, bit_out=shifter MSB; shift left; history <= {history, bit}; fill count +1 (saturating at PAT_W); bit index +1 (1-based, saturating).
  - After WORD_W bits: go to DONE if the latched last is set, else WAIT.
  - One bubble cycle per word, so throughput is 1 word per WORD_W+1 cycles.
- Match: fill count (after update) >= len and the low len history bits equal the low len pattern bits.
  - det_pulse is registered: high the cycle after the completing bit's bit_valid.
  - match_cnt increments on the same cycle and saturates at 2^CNT_W-1.
  - overlap=0: on a match, fill count is reset to 0, so the next match needs len fresh bits.
- DONE: done=1 for one cycle, then IDLE. match_cnt holds until the next start.
- abort: in WAIT/SHIFT/DONE, go to IDLE next cycle. done is not pulsed; match_cnt is retained; a det_pulse already registered still fires. abort has priority over the word handshake and over the last-bit transition. abort in IDLE has no effect.
- Matches span word boundaries; history is not cleared between words of a run.
- rst mid-run: immediate return to reset values on the next edge.

Optional Feature:
SEQ_CTRL_FIRST_IDX_EN
- Defined: on the first match after start, first_idx captures the 1-based bit index of the completing bit and first_vld is set. Both are registered alongside det_pulse, held until the next start, and cleared by start.
- Undefined: first_idx and first_vld are tied to 0; no capture logic is built.

Test Plan:
- Pattern 4'b0001, len 4, overlap 1; start; word 8'b0001_0001 with last → det_pulse after bits 4 and 8; match_cnt=2; done one cycle after bit 8; busy low afterwards.
- Pattern 4'b0101, len 4; word 8'b0101_0101 last → overlap=1 gives match_cnt=3 (bits 4, 6, 8); rerun with overlap=0 gives match_cnt=2 (bits 4, 8).
- Pattern 4'b0001; words 8'b1111_1000 (last=0) then 8'b0111_1111 (last=1) → single match across the boundary at bit 10; match_cnt=1; first_idx=10 with feature on; s_ready high for exactly one cycle before each word.
- Start, word 8'hA5, abort asserted on the 3rd SHIFT cycle → IDLE next cycle; bit_valid low; done never asserts; s_ready stays 0.
- CNT_W=2, pattern 1'b1, len 1; word 8'hFF last → match_cnt saturates at 3; det_pulse asserted 8 cycles.
- cfg_we with pattern 4'b1111 while busy → ignored, run completes using old pattern; cfg_len=0 in IDLE → behaves as len 1.
